// File: rtl/input_vc_buffer.sv
// Receive-side input buffer for one router port: sorts link flits into
// per-VC circular FIFOs, presents the selected VC's head and returns credits.
`ifndef VCHW
`define VCHW 0
`endif
`ifndef DATAW
`define DATAW 7
`endif

module input_vc_buffer #(
    parameter int NUM_VC = 1 << (`VCHW + 1),
    parameter int DEPTH  = 4,
    parameter int PTRW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`DATAW:0]   idata,
    input  logic              ivalid,
    input  logic [`VCHW:0]    ivch,
    input  logic [`VCHW:0]    rd_vch,
    input  logic              rd_en,
    output logic [`DATAW:0]   odata,
    output logic [NUM_VC-1:0] ovc_empty,
    output logic [NUM_VC-1:0] ovc_full,
    output logic              ocredit_valid,
    output logic [`VCHW:0]    ocredit_vch,
    output logic              oovf_err
);
    localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

    logic [`DATAW:0]   mem    [NUM_VC][DEPTH];
    logic [PTRW-1:0]   wr_ptr [NUM_VC];
    logic [PTRW-1:0]   rd_ptr [NUM_VC];
    logic [PTRW:0]     count  [NUM_VC];

    logic              pop_ok;
    logic              wr_ok;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;
    logic              credit_valid;
    logic [`VCHW:0]    credit_vch;
    logic              ovf_err;

    // A write to a full VC is still accepted when that same VC pops this cycle.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        pop_ok = rd_en && (count[rd_vch] != '0);
        wr_ok  = ivalid && ((count[ivch] != FULL_CNT) || (pop_ok && (rd_vch == ivch)));
        if (wr_ok) begin
            wr_hit[ivch] = 1'b1;
        end
        if (pop_ok) begin
            rd_hit[rd_vch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[ivch][wr_ptr[ivch]] <= idata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            credit_valid <= 1'b0;
            credit_vch   <= '0;
            ovf_err      <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (wr_hit[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PTRW'(1);
                end
                if (rd_hit[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PTRW'(1);
                end
                if (wr_hit[v] && !rd_hit[v]) begin
                    count[v] <= count[v] + (PTRW + 1)'(1);
                end else if (!wr_hit[v] && rd_hit[v]) begin
                    count[v] <= count[v] - (PTRW + 1)'(1);
                end
            end
            credit_valid <= pop_ok;
            credit_vch   <= pop_ok ? rd_vch : '0;
            if (ivalid && !wr_ok) begin
                ovf_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            ovc_empty[v] = (count[v] == '0);
            ovc_full[v]  = (count[v] == FULL_CNT);
        end
    end

    assign odata         = mem[rd_vch][rd_ptr[rd_vch]];
    assign ocredit_valid = credit_valid;
    assign ocredit_vch   = credit_vch;
    assign oovf_err      = ovf_err;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Bench for input_vc_buffer: table of write/pop vectors with expected head data,
// checked against a per-VC queue model and a credit scoreboard.
`ifndef VCHW
`define VCHW 0
`endif
`ifndef DATAW
`define DATAW 7
`endif

module tb_input_vc_buffer;
    localparam int DW    = `DATAW + 1;
    localparam int VCW   = `VCHW + 1;
    localparam int NV    = 1 << VCW;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [DW-1:0]  idata = '0;
    logic           ivalid = 1'b0;
    logic [VCW-1:0] ivch = '0;
    logic [VCW-1:0] rd_vch = '0;
    logic           rd_en = 1'b0;
    logic [DW-1:0]  odata;
    logic [NV-1:0]  ovc_empty;
    logic [NV-1:0]  ovc_full;
    logic           ocredit_valid;
    logic [VCW-1:0] ocredit_vch;
    logic           oovf_err;

    input_vc_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .rd_vch(rd_vch), .rd_en(rd_en), .odata(odata), .ovc_empty(ovc_empty),
        .ovc_full(ovc_full), .ocredit_valid(ocredit_valid),
        .ocredit_vch(ocredit_vch), .oovf_err(oovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           wv;
        logic [VCW-1:0] wvc;
        logic [DW-1:0]  wd;
        logic           re;
        logic [VCW-1:0] rvc;
        bit             chk;
        logic [DW-1:0]  eod;
    } vec_t;

    vec_t           tbl[$];
    logic [DW-1:0]  mq[NV][$];
    logic [VCW-1:0] cq[$];
    bit             mo;
    int             errors = 0;
    int             checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic wv, input int wvc, input int wd,
                                input logic re, input int rvc, input bit c, input int eod);
        vec_t t;
        t.wv = wv; t.wvc = VCW'(wvc); t.wd = DW'(wd);
        t.re = re; t.rvc = VCW'(rvc); t.chk = c; t.eod = DW'(eod);
        tbl.push_back(t);
    endfunction

    task automatic cyc(input logic wv, input logic [VCW-1:0] wvc, input logic [DW-1:0] wd,
                       input logic re, input logic [VCW-1:0] rvc, input bit c,
                       input logic [DW-1:0] eod);
        logic [NV-1:0] ev, fv;
        bit pop_ok, acc;
        ivalid = wv; ivch = wvc; idata = wd; rd_en = re; rd_vch = rvc;
        #2;
        for (int v = 0; v < NV; v++) begin
            ev[v] = (mq[v].size() == 0);
            fv[v] = (mq[v].size() == DEPTH);
        end
        chk("empty", 32'(ovc_empty), 32'(ev));
        chk("full", 32'(ovc_full), 32'(fv));
        if (mq[rvc].size() > 0) chk("odata_model", 32'(odata), 32'(mq[rvc][0]));
        if (c) chk("odata_vec", 32'(odata), 32'(eod));
        pop_ok = re && (mq[rvc].size() > 0);
        acc = wv && ((mq[wvc].size() < DEPTH) || (pop_ok && (rvc == wvc)));
        if (pop_ok) begin
            void'(mq[rvc].pop_front());
            cq.push_back(rvc);
        end
        if (acc) mq[wvc].push_back(wd);
        else if (wv) mo = 1'b1;
        @(posedge clk);
        #1;
        if (cq.size() > 0) begin
            logic [VCW-1:0] e;
            e = cq.pop_front();
            chk("credit_valid", 32'(ocredit_valid), 32'd1);
            chk("credit_vch", 32'(ocredit_vch), 32'(e));
        end else begin
            chk("credit_idle", 32'(ocredit_valid), 32'd0);
            chk("credit_vch_idle", 32'(ocredit_vch), 32'd0);
        end
        chk("ovf", 32'(oovf_err), 32'(mo));
    endtask

    // Reset with a write and optional pop in the same cycle; reset must win.
    task automatic rst_cyc(input logic re, input logic [VCW-1:0] rvc);
        rst = 1'b1; ivalid = 1'b1; ivch = '0; idata = 8'h77; rd_en = re; rd_vch = rvc;
        @(posedge clk);
        #1;
        rst = 1'b0; ivalid = 1'b0; rd_en = 1'b0;
        for (int v = 0; v < NV; v++) mq[v].delete();
        cq.delete();
        mo = 1'b0;
        #1;
        chk("rst_empty", 32'(ovc_empty), 32'((1 << NV) - 1));
        chk("rst_full", 32'(ovc_full), 32'd0);
        chk("rst_credit", 32'(ocredit_valid), 32'd0);
        chk("rst_credit_vch", 32'(ocredit_vch), 32'd0);
        chk("rst_ovf", 32'(oovf_err), 32'd0);
    endtask

    initial begin
        mo = 1'b0;
        rst_cyc(1'b0, '0);

        // Fill VC0 with 1..4, drain in order
        for (int i = 1; i <= 4; i++) add(1, 0, i, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 0, 0, 1, 0, 1, i);
        add(0, 0, 0, 0, 0, 0, 0);
        // Interleaved VCs
        add(1, 0, 'hA0, 0, 0, 0, 0);
        add(1, 1, 'hB0, 0, 0, 0, 0);
        add(1, 0, 'hA1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 'hB0);
        add(0, 0, 0, 1, 0, 1, 'hA0);
        add(0, 0, 0, 1, 0, 1, 'hA1);
        // Pop on empty VC1
        add(0, 0, 0, 1, 1, 0, 0);
        // Full VC0 with simultaneous write and pop
        for (int i = 0; i < 4; i++) add(1, 0, 'h20 + i, 0, 0, 0, 0);
        add(1, 0, 'h55, 1, 0, 1, 'h20);
        add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) add(0, 0, 0, 1, 0, 1, 'h20 + i);
        add(0, 0, 0, 1, 0, 1, 'h55);
        // Streaming across the pointer wrap
        add(1, 0, 'h30, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 0, 'h31 + i, 1, 0, 1, 'h30 + i);
        add(0, 0, 0, 1, 0, 1, 'h3A);
        add(0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++)
            cyc(tbl[k].wv, tbl[k].wvc, tbl[k].wd, tbl[k].re, tbl[k].rvc, tbl[k].chk, tbl[k].eod);

        // Overflow on VC1: fifth flit dropped, flag sticky
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, DW'(8'h10 + i), 1'b0, '0, 1'b0, '0);
        cyc(1'b1, 1'b1, 8'hFF, 1'b0, '0, 1'b0, '0);
        chk("ovf_set", 32'(oovf_err), 32'd1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, DW'(8'h10 + i));
        cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
        chk("ovf_sticky", 32'(oovf_err), 32'd1);

        // Reset while VC0 holds 3 flits and a pop is active
        for (int i = 0; i < 3; i++) cyc(1'b1, '0, DW'(8'h60 + i), 1'b0, '0, 1'b0, '0);
        rst_cyc(1'b1, '0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Receive-side input buffer for one router input port. It takes the flit stream a neighbour router's crossbar output mux drives onto the link (data, valid, virtual-channel tag) and sorts each flit into a per-VC FIFO. It presents each VC's head flit to the local route/switch logic. On every flit pop it returns one credit upstream, so the sender can track free slots per VC.

## Interface
Parameters:
- `NUM_VC`, default `1 << (`VCHW+1)`: number of virtual channels. Must equal `2^(`VCHW+1)`.
- `DEPTH`, default 4: flit slots per VC. Power of two, ≥2.
- `PTRW`, default `$clog2(DEPTH)`: read/write pointer width per VC. Each VC's count is `PTRW+1` bits.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `idata`  in  `DATAW+1`: link flit data.
- `ivalid`  in  1: link flit valid.
- `ivch`  in  `VCHW+1`: VC tag of the link flit.
- `rd_vch`  in  `VCHW+1`: VC whose head flit is presented on `odata`.
- `rd_en`  in  1: pop the head of `rd_vch` this cycle.
- `odata`  out  `DATAW+1`: head flit of `rd_vch`. Combinational, first-word-fall-through.
- `ovc_empty`  out  `NUM_VC`: bit v = VC v holds 0 flits.
- `ovc_full`  out  `NUM_VC`: bit v = VC v holds `DEPTH` flits.
- `ocredit_valid`  out  1: registered credit return, one pulse per pop.
- `ocredit_vch`  out  `VCHW+1`: VC the credit belongs to.
- `oovf_err`  out  1: sticky flag, set by a write to a full VC.

## Operation
- Storage: `NUM_VC` independent circular FIFOs of `DEPTH` × `DATAW+1` bits. Each has its own `wr_ptr`, `rd_ptr` and `count`.
- Write: when `ivalid`=1, the flit is written at `wr_ptr[ivch]`. Then `wr_ptr` increments modulo `DEPTH`, wrapping from `DEPTH-1` to 0, and `count` increments.
- Write to a full VC (`count==DEPTH`, with no pop of that VC in the same cycle):
  - the flit is dropped and no pointer or count changes;
  - `oovf_err` sets and holds until `rst`.
- Read: when `rd_en`=1 and `ovc_empty[rd_vch]`=0:
  - `rd_ptr[rd_vch]` increments modulo `DEPTH` and `count` decrements;
  - a credit is scheduled.
- `rd_en`=1 on an empty VC is ignored: no state change, no credit, no error.
- Same-cycle write and pop, same VC:
  - both take effect and `count` is unchanged;
  - if the VC was full, the write is accepted (the pop frees the slot) and `oovf_err` is not set;
  - if the VC was empty, the pop is ignored and the write lands.
- Same-cycle write and pop, different VCs: fully independent.
- `odata` = `mem[rd_vch][rd_ptr[rd_vch]]`. When the selected VC is empty the value is don't-care; the bench masks it using `ovc_empty`.
- `ovc_empty` and `ovc_full` are decoded from the registered `count`, so they reflect state after the last clock edge.
- Credit: on a valid pop, the next cycle shows `ocredit_valid`=1 and `ocredit_vch`=the popped VC. Otherwise `ocredit_valid`=0 and `ocredit_vch` holds 0. At most one credit per cycle.
- No state machine beyond the per-VC pointer and count registers plus the credit register.

## Timing
- Reset (`rst`=1 at a rising edge): all pointers and counts go to 0, giving:
  - `ovc_empty` = all ones, `ovc_full` = 0;
  - `ocredit_valid` = 0, `ocredit_vch` = 0, `oovf_err` = 0.
- Memory contents are not reset.
- Reset has priority over a same-cycle write or pop. Flits in flight are discarded and no credit is issued for them.
- Write-to-read latency: a flit written at edge N is visible on `odata` and clears `ovc_empty` after edge N, so it can be popped in cycle N+1.
- Pop-to-credit latency: a pop sampled at edge N gives `ocredit_valid`=1 during cycle N+1, for exactly one cycle per pop.
- Back-to-back pops give back-to-back credit pulses.
- `odata` path: combinational from `rd_vch` and registered pointers. There is no combinational path from `idata` or `ivalid` to any output.

## Test plan
- Reset, then 4 writes to VC0 (data 0x1, 0x2, 0x3, 0x4; `DEPTH`=4):
  - `ovc_full[0]`=1, `ovc_empty[0]`=0;
  - 4 pops return 0x1..0x4 in order, with 4 credit pulses, `ocredit_vch`=0, each one cycle after its pop;
  - afterwards `ovc_empty[0]`=1.
- Interleave writes VC0 = 0xA0, VC1 = 0xB0, VC0 = 0xA1, then pop VC1 and VC0 twice → `odata` gives 0xB0, 0xA0, 0xA1, and credit VCs 1, 0, 0.
- Fill VC1, then a 5th write of 0xFF:
  - `oovf_err`=1, the count stays 4;
  - draining returns only the first 4 flits;
  - the flag stays 1 until `rst`.
- Full VC0, same-cycle write 0x55 and pop:
  - the pop returns the oldest flit, the count stays 4 and `oovf_err` stays 0;
  - 0x55 emerges 4 pops later.
- Pop on an empty VC1 → no credit, all counts unchanged.
- Run 10 write/pop cycles on VC0 to cross the pointer wrap → FIFO order is preserved.
- Assert `rst` while VC0 holds 3 flits and a pop is active → next cycle `ovc_empty`=all ones and `ocredit_valid`=0.
